// File: rtl/io_sw_in_pkg.sv
// Shared definitions for the io_sw input peripheral: register offsets,
// debounce state encoding and the decoded LSU request payload.
package io_sw_in_pkg;

  localparam int unsigned BUS_W = 32;
  localparam int unsigned OFF_W = 2;

  localparam logic [OFF_W-1:0] SW_OFF  = 2'd0;
  localparam logic [OFF_W-1:0] CHG_OFF = 2'd1;
  localparam logic [OFF_W-1:0] MSK_OFF = 2'd2;
  localparam logic [OFF_W-1:0] RSV_OFF = 2'd3;

  typedef enum logic {
    DB_IDLE = 1'b0,
    DB_WAIT = 1'b1
  } db_state_e;

  // Request after window decode; rd/wr are already qualified by the hit.
  typedef struct packed {
    logic             rd;
    logic             wr;
    logic [OFF_W-1:0] off;
    logic [BUS_W-1:0] wdata;
  } reg_req_t;

endpackage

// File: rtl/io_sw_in_debounce.sv
// Two-flop synchroniser plus whole-word debounce; emits the committed word
// and a single-cycle commit strobe carrying the bits that changed.
module io_sw_in_debounce
  import io_sw_in_pkg::*;
#(
  parameter int unsigned SW_W         = 32,
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [SW_W-1:0] io_sw_i,
  output logic [SW_W-1:0] sw_db,
  output logic            commit_c,
  output logic [SW_W-1:0] diff_c
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SW_W-1:0]  sw_meta;
  logic [SW_W-1:0]  sw_sync;
  logic [SW_W-1:0]  cand;
  logic [CNT_W-1:0] cnt;
  db_state_e        state;

  // Commit strobe mirrors the committing branch of the FSM below.
  assign commit_c = (state == DB_WAIT) && (sw_sync != sw_db) &&
                    (sw_sync == cand) && (cnt == CNT_LAST);
  assign diff_c   = cand ^ sw_db;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_meta <= '0;
      sw_sync <= '0;
      sw_db   <= '0;
      cand    <= '0;
      cnt     <= '0;
      state   <= DB_IDLE;
    end else begin
      sw_meta <= io_sw_i;
      sw_sync <= sw_meta;
      case (state)
        DB_IDLE: begin
          if (sw_sync != sw_db) begin
            cand  <= sw_sync;
            cnt   <= '0;
            state <= DB_WAIT;
          end
        end
        DB_WAIT: begin
          if (sw_sync == sw_db) begin
            // Input fell back to the committed value: drop the candidate.
            state <= DB_IDLE;
          end else if (sw_sync != cand) begin
            cand <= sw_sync;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            sw_db <= cand;
            state <= DB_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= DB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/io_sw_in.sv
// Memory-mapped switch input peripheral: debounced switch word, sticky
// change register with mask and level irq, 1-cycle LSU load latency.
module io_sw_in
  import io_sw_in_pkg::*;
#(
  parameter int unsigned SW_W         = 32,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h7800
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [SW_W-1:0] io_sw_i,
  input  logic [31:0]     addr_i,
  input  logic            rden_i,
  input  logic            wren_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  output logic            rvalid_o,
  output logic            irq_o
);

  logic [SW_W-1:0]  sw_db;
  logic             commit_c;
  logic [SW_W-1:0]  diff_c;
  logic [SW_W-1:0]  change;
  logic [SW_W-1:0]  mask;
  logic             hit_c;
  reg_req_t         req_c;
  logic [BUS_W-1:0] rd_mux_c;
  logic [SW_W-1:0]  w1c_c;
  logic [SW_W-1:0]  set_c;
  logic             addr_unused;

  io_sw_in_debounce #(
    .SW_W         (SW_W),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .io_sw_i  (io_sw_i),
    .sw_db    (sw_db),
    .commit_c (commit_c),
    .diff_c   (diff_c)
  );

  // Word-aligned window; byte offset bits do not select anything.
  assign addr_unused = ^addr_i[1:0];
  assign hit_c       = (addr_i[31:4] == BASE_ADDR[31:4]);

  assign req_c = '{rd:    rden_i & hit_c,
                   wr:    wren_i & hit_c,
                   off:   addr_i[3:2],
                   wdata: wdata_i};

  always_comb begin
    rd_mux_c = '0;
    case (req_c.off)
      SW_OFF:  rd_mux_c = BUS_W'(sw_db);
      CHG_OFF: rd_mux_c = BUS_W'(change);
      MSK_OFF: rd_mux_c = BUS_W'(mask);
      default: rd_mux_c = '0;
    endcase
  end

  always_comb begin
    w1c_c = '0;
    set_c = '0;
    if (req_c.wr && (req_c.off == CHG_OFF)) begin
      w1c_c = req_c.wdata[SW_W-1:0];
    end
    if (commit_c) begin
      set_c = diff_c;
    end
  end

  // Set is applied after clear so a same-cycle commit survives the W1C.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      change   <= '0;
      mask     <= '0;
      irq_o    <= 1'b0;
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else begin
      change   <= (change & ~w1c_c) | set_c;
      irq_o    <= |(change & mask);
      rvalid_o <= req_c.rd;
      if (req_c.wr && (req_c.off == MSK_OFF)) begin
        mask <= req_c.wdata[SW_W-1:0];
      end
      if (req_c.rd) begin
        rdata_o <= rd_mux_c;
      end
    end
  end

endmodule

// File: tb/tb_io_sw_in.sv
// Bench for io_sw_in: directed corner sequences, a decode vector table and
// randomized traffic checked against a run-length reference model.
module tb_io_sw_in;

  localparam int unsigned DB = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [31:0] io_sw_i = '0;
  logic [31:0] addr_i = '0;
  logic        rden_i = 1'b0;
  logic        wren_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        irq_o;

  io_sw_in #(
    .SW_W         (32),
    .DEBOUNCE_CYC (DB),
    .BASE_ADDR    (32'h7800)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .io_sw_i  (io_sw_i),
    .addr_i   (addr_i),
    .rden_i   (rden_i),
    .wren_i   (wren_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o),
    .irq_o    (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_db, m_chg, m_msk, m_rdata;
  logic        m_rvalid, m_irq;
  logic [31:0] hist[$];
  logic [31:0] run_val;
  int          run_len;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic        rv;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_db = '0; m_chg = '0; m_msk = '0; m_rdata = '0;
    m_rvalid = 1'b0; m_irq = 1'b0;
    hist = {32'h0, 32'h0};
    run_val = '0;
    run_len = 0;
  endtask

  // The DUT sees each sample two edges later; a value is committed when it
  // has been seen for DB+1 consecutive edges and differs from the word.
  task automatic model_edge();
    logic        hit;
    logic [1:0]  off;
    logic [31:0] rv, p, set_b, clr_b;
    logic        irq_n;
    hit = ((addr_i >> 4) == (32'h7800 >> 4));
    off = addr_i[3:2];
    case (off)
      2'd0:    rv = m_db;
      2'd1:    rv = m_chg;
      2'd2:    rv = m_msk;
      default: rv = 32'h0;
    endcase
    m_rvalid = rden_i && hit;
    if (m_rvalid) m_rdata = rv;
    irq_n = |(m_chg & m_msk);
    hist.push_back(io_sw_i);
    p = hist.pop_front();
    if (run_len > 0 && p == run_val) run_len++;
    else begin
      run_val = p;
      run_len = 1;
    end
    set_b = '0;
    if (run_len == int'(DB) + 1 && run_val != m_db) begin
      set_b = run_val ^ m_db;
      m_db  = run_val;
    end
    clr_b = (wren_i && hit && off == 2'd1) ? wdata_i : 32'h0;
    m_chg = (m_chg & ~clr_b) | set_b;
    if (wren_i && hit && off == 2'd2) m_msk = wdata_i;
    m_irq = irq_n;
  endtask

  task automatic step(input logic [31:0] sw, input logic [31:0] addr,
                      input logic rd, input logic wr, input logic [31:0] wd);
    io_sw_i = sw; addr_i = addr; rden_i = rd; wren_i = wr; wdata_i = wd;
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    chk("m_rdata", rdata_o, m_rdata);
    chk("m_rvalid", 32'(rvalid_o), 32'(m_rvalid));
    chk("m_irq", 32'(irq_o), 32'(m_irq));
    chk("m_sw_db", dut.u_debounce.sw_db, m_db);
  endtask

  task automatic idle(input logic [31:0] sw);
    step(sw, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic load(input logic [31:0] sw, input logic [31:0] addr);
    step(sw, addr, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic store(input logic [31:0] sw, input logic [31:0] addr, input logic [31:0] wd);
    step(sw, addr, 1'b0, 1'b1, wd);
  endtask

  // Async reset asserted mid-cycle; outputs must drop before any edge.
  task automatic do_reset(input logic [31:0] sw);
    io_sw_i = sw; rden_i = 1'b0; wren_i = 1'b0;
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] addrs[6];
    logic [31:0] cur;
    int          hold;
    logic [1:0]  op;

    vecs[0]  = '{32'h0000_780C, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[1]  = '{32'h0000_7810, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[2]  = '{32'h0000_7800, 1'b0, 1'b1, 32'h0000_DEAD, 1'b0, 32'h0};
    vecs[3]  = '{32'h0000_7800, 1'b1, 1'b0, 32'h0,         1'b1, 32'h3};
    vecs[4]  = '{32'h0000_7808, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1};
    vecs[5]  = '{32'h0000_7808, 1'b1, 1'b1, 32'h0000_00F0, 1'b1, 32'h1};
    vecs[6]  = '{32'h0000_7808, 1'b1, 1'b0, 32'h0,         1'b1, 32'hF0};
    vecs[7]  = '{32'h0001_7800, 1'b1, 1'b0, 32'h0,         1'b0, 32'hF0};
    vecs[8]  = '{32'h0000_7802, 1'b1, 1'b0, 32'h0,         1'b1, 32'h3};
    vecs[9]  = '{32'h0000_7804, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h3};
    vecs[10] = '{32'h0000_7804, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[11] = '{32'h0000_780C, 1'b0, 1'b1, 32'h5,         1'b0, 32'h0};
    vecs[12] = '{32'h0000_780C, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0};

    // Reset with switches high; SW reads 0 until the debounce completes.
    do_reset(32'hFFFF);
    for (int i = 1; i <= 9; i++) begin
      load(32'hFFFF, 32'h7800);
      chk("rst_sw_db", dut.u_debounce.sw_db, (i >= 7) ? 32'hFFFF : 32'h0);
      chk("rst_load", rdata_o, (i >= 8) ? 32'hFFFF : 32'h0);
    end
    repeat (10) idle(32'h0);
    store(32'h0, 32'h7804, 32'hFFFF_FFFF);

    // Step 0 -> A5: committed exactly 7 edges after the first sample.
    for (int i = 1; i <= 8; i++) begin
      load(32'hA5, 32'h7800);
      chk("step_sw_db", dut.u_debounce.sw_db, (i >= 7) ? 32'hA5 : 32'h0);
    end
    load(32'hA5, 32'h7800);
    chk("step_sw", rdata_o, 32'hA5);
    load(32'hA5, 32'h7804);
    chk("step_chg", rdata_o, 32'hA5);

    repeat (10) idle(32'h0);
    store(32'h0, 32'h7804, 32'hFFFF_FFFF);
    store(32'h0, 32'h7808, 32'hFFFF_FFFF);

    // Three-cycle glitch with every bit unmasked must leave no trace.
    for (int i = 0; i < 13; i++) begin
      idle((i < 3) ? 32'h1 : 32'h0);
      chk("glitch_irq", 32'(irq_o), 32'h0);
      chk("glitch_sw_db", dut.u_debounce.sw_db, 32'h0);
    end
    load(32'h0, 32'h7800);
    chk("glitch_sw", rdata_o, 32'h0);
    load(32'h0, 32'h7804);
    chk("glitch_chg", rdata_o, 32'h0);

    // IRQ: CHANGE[0] sets at edge 7, irq follows at edge 8.
    store(32'h0, 32'h7808, 32'h1);
    for (int i = 1; i <= 9; i++) begin
      idle(32'h1);
      chk("irq_rise", 32'(irq_o), (i >= 8) ? 32'h1 : 32'h0);
    end
    store(32'h1, 32'h7804, 32'h1);
    chk("irq_lag", 32'(irq_o), 32'h1);
    idle(32'h1);
    chk("irq_clear", 32'(irq_o), 32'h0);

    // W1C of bit1 lands on the same edge that bit1 commits.
    for (int i = 1; i <= 7; i++) begin
      if (i == 7) store(32'h3, 32'h7804, 32'h2);
      else idle(32'h3);
    end
    chk("race_sw_db", dut.u_debounce.sw_db, 32'h3);
    load(32'h3, 32'h7804);
    chk("race_chg", rdata_o, 32'h2);

    // Decode vectors, starting from SW=3 CHANGE=2 MASK=1.
    for (int i = 0; i < 13; i++) begin
      step(32'h3, vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wd);
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid_o), 32'(vecs[i].rv));
      chk($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].rdata);
    end

    // Randomized traffic, including a reset in the middle of a debounce.
    addrs[0] = 32'h7800; addrs[1] = 32'h7804; addrs[2] = 32'h7808;
    addrs[3] = 32'h780C; addrs[4] = 32'h7810; addrs[5] = 32'h7804;
    cur  = 32'h3;
    hold = 0;
    for (int n = 0; n < 400; n++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0:       cur = 32'h0;
          1:       cur = 32'hA5;
          2:       cur = 32'h3;
          default: cur = $urandom;
        endcase
        hold = $urandom_range(1, 8);
      end
      hold--;
      if (n == 200) do_reset(cur);
      op = 2'($urandom_range(0, 3));
      step(cur, addrs[$urandom_range(0, 5)], op[0], op[1], $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
